// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_write_arbiter.
// FIFO_ARB_BURST_LOCK_EN adds the per-requester req_last end-of-burst flags.
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CAP    = 254
);
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    fifo_write_e;
  logic [DATA_W-1:0]       fifo_write_data;
  logic [SRC_W-1:0]        fifo_src;
  logic                    fifo_read_e;
  logic [CNT_W-1:0]        level;
  logic                    full;
  logic                    empty;
`ifdef FIFO_ARB_BURST_LOCK_EN
  logic [N_REQ-1:0]        req_last;
`endif

  modport master (
    output req, req_data, fifo_read_e,
`ifdef FIFO_ARB_BURST_LOCK_EN
    output req_last,
`endif
    input  gnt, fifo_write_e, fifo_write_data, fifo_src, level, full, empty
  );

  modport slave (
    input  req, req_data, fifo_read_e,
`ifdef FIFO_ARB_BURST_LOCK_EN
    input  req_last,
`endif
    output gnt, fifo_write_e, fifo_write_data, fifo_src, level, full, empty
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with its own occupancy counter.
// Optional FIFO_ARB_BURST_LOCK_EN keeps the grant on one requester until req_last.
module fifo_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CAP    = 254
) (
  input logic                clk,
  input logic                reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int SRC_W = $clog2(N_REQ);

  logic [SRC_W-1:0]  last;
  logic [SRC_W-1:0]  win;
  logic              found;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  gnt_c;
  logic [CNT_W-1:0]  level;
  logic              space;
  logic              accept;
  logic              pop;
  logic              write_e;
  logic [DATA_W-1:0] write_data;
  logic [SRC_W-1:0]  src;

`ifdef FIFO_ARB_BURST_LOCK_EN
  typedef enum logic {OPEN, LOCKED} lock_state_t;
  lock_state_t      lock_state;
  logic [SRC_W-1:0] lock_id;
`endif

  always_comb begin
    elig = '1;
`ifdef FIFO_ARB_BURST_LOCK_EN
    if (lock_state == LOCKED) begin
      elig          = '0;
      elig[lock_id] = 1'b1;
    end
`endif
  end

  // Rotating search starting just after the last winner; k == N_REQ revisits last itself.
  always_comb begin
    found = 1'b0;
    win   = last;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      logic [SRC_W-1:0] cand;
      cand = SRC_W'((int'(last) + int'(k)) % N_REQ);
      if (!found && bus.req[cand] && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A pop in the same cycle does not open space: grant looks only at the current level.
  assign space  = (level < CNT_W'(CAP));
  assign accept = found && space;
  assign pop    = bus.fifo_read_e && (level != '0);

  always_comb begin
    gnt_c = '0;
    if (accept) gnt_c[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_e    <= 1'b0;
      write_data <= '0;
      src        <= '0;
      level      <= '0;
      last       <= SRC_W'(N_REQ - 1);
`ifdef FIFO_ARB_BURST_LOCK_EN
      lock_state <= OPEN;
      lock_id    <= '0;
`endif
    end else begin
      write_e <= accept;
      if (accept) begin
        write_data <= bus.req_data[win*DATA_W +: DATA_W];
        src        <= win;
        last       <= win;
`ifdef FIFO_ARB_BURST_LOCK_EN
        if (lock_state == OPEN && !bus.req_last[win]) begin
          lock_state <= LOCKED;
          lock_id    <= win;
        end else if (lock_state == LOCKED && bus.req_last[win]) begin
          lock_state <= OPEN;
        end
`endif
      end
      if (accept && !pop)      level <= level + 1'b1;
      else if (pop && !accept) level <= level - 1'b1;
    end
  end

  assign bus.gnt             = gnt_c;
  assign bus.fifo_write_e    = write_e;
  assign bus.fifo_write_data = write_data;
  assign bus.fifo_src        = src;
  assign bus.level           = level;
  assign bus.full            = (level == CNT_W'(CAP));
  assign bus.empty           = (level == '0);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (CAP=4) with a write-beat scoreboard queue.
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] dat [4];
  logic [3:0] prev_gnt = '0;
  logic [3:0] rl = '0;
  logic [9:0] exp_q [$];

  fifo_write_arbiter_if #(.N_REQ(4), .DATA_W(8), .CAP(4)) bus ();

  fifo_write_arbiter #(.N_REQ(4), .DATA_W(8), .CAP(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: drive, check grant, then check registered results after the rising edge.
  task automatic cyc(input logic [3:0] rq, input logic rd, input logic [3:0] eg,
                     input int el, input string tag);
    logic [9:0] e;
    for (int i = 0; i < 4; i++)
      if (!rq[i] || prev_gnt[i]) dat[i] = 8'($urandom);
    bus.req         = rq;
    bus.req_data    = {dat[3], dat[2], dat[1], dat[0]};
    bus.fifo_read_e = rd;
`ifdef FIFO_ARB_BURST_LOCK_EN
    bus.req_last    = rl;
`endif
    #1;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    for (int i = 0; i < 4; i++)
      if (eg[i]) exp_q.push_back({2'(i), dat[i]});
    prev_gnt = eg;
    @(posedge clk);
    #1;
    chk({tag, ".we"}, 32'(bus.fifo_write_e), 32'(eg != 4'b0000));
    if (bus.fifo_write_e === 1'b1) begin
      chk({tag, ".q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, ".data"}, 32'(bus.fifo_write_data), 32'(e[7:0]));
        chk({tag, ".src"},  32'(bus.fifo_src),        32'(e[9:8]));
      end
    end
    chk({tag, ".level"}, 32'(bus.level), 32'(el));
    chk({tag, ".full"},  32'(bus.full),  32'(el == 4));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(el == 0));
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    bus.req         = '0;
    bus.req_data    = '0;
    bus.fifo_read_e = 1'b0;
`ifdef FIFO_ARB_BURST_LOCK_EN
    bus.req_last    = '0;
`endif
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    #2;
    chk("rst.we",    32'(bus.fifo_write_e),    32'd0);
    chk("rst.data",  32'(bus.fifo_write_data), 32'd0);
    chk("rst.src",   32'(bus.fifo_src),        32'd0);
    chk("rst.level", 32'(bus.level),           32'd0);
    chk("rst.empty", 32'(bus.empty),           32'd1);
    chk("rst.full",  32'(bus.full),            32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin with all requesting, through a full stall.
    cyc(4'b1111, 1'b0, 4'b0001, 1, "rr0");
    cyc(4'b1111, 1'b0, 4'b0010, 2, "rr1");
    cyc(4'b1111, 1'b0, 4'b0100, 3, "rr2");
    cyc(4'b1111, 1'b0, 4'b1000, 4, "rr3");
    cyc(4'b1111, 1'b1, 4'b0000, 3, "full_pop");
    cyc(4'b1111, 1'b0, 4'b0001, 4, "rr_wrap");
    cyc(4'b0000, 1'b1, 4'b0000, 3, "drain_a");
    cyc(4'b0000, 1'b1, 4'b0000, 2, "drain_b");

    // Simultaneous accept and pop, then underflow guard.
    cyc(4'b1111, 1'b1, 4'b0010, 2, "acc_pop");
    cyc(4'b0000, 1'b1, 4'b0000, 1, "pop1");
    cyc(4'b0000, 1'b1, 4'b0000, 0, "pop0");
    cyc(4'b0000, 1'b1, 4'b0000, 0, "pop_empty");

    // last=1, req=1001.
    cyc(4'b1001, 1'b0, 4'b1000, 1, "r9_a");
    cyc(4'b1001, 1'b0, 4'b0001, 2, "r9_b");
    cyc(4'b1001, 1'b0, 4'b1000, 3, "r9_c");
    cyc(4'b0110, 1'b1, 4'b0010, 3, "r6");

    // Asynchronous reset with a beat in flight.
    chk("pre_rst.we",    32'(bus.fifo_write_e), 32'd1);
    chk("pre_rst.level", 32'(bus.level),        32'd3);
    bus.req = 4'b1111;
    reset   = 1'b1;
    #1;
    chk("async_rst.we",    32'(bus.fifo_write_e), 32'd0);
    chk("async_rst.level", 32'(bus.level),        32'd0);
    chk("async_rst.empty", 32'(bus.empty),        32'd1);
    chk("async_rst.src",   32'(bus.fifo_src),     32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("in_rst.we",    32'(bus.fifo_write_e), 32'd0);
    chk("in_rst.level", 32'(bus.level),        32'd0);
    @(negedge clk);
    reset    = 1'b0;
    prev_gnt = '0;
    cyc(4'b1111, 1'b0, 4'b0001, 1, "post_rst");
    cyc(4'b0000, 1'b1, 4'b0000, 0, "post_rst_drain");

    // Single requester fills the FIFO, stalls, resumes after one pop.
    cyc(4'b0100, 1'b0, 4'b0100, 1, "fill1");
    cyc(4'b0100, 1'b0, 4'b0100, 2, "fill2");
    cyc(4'b0100, 1'b0, 4'b0100, 3, "fill3");
    cyc(4'b0100, 1'b0, 4'b0100, 4, "fill4");
    cyc(4'b0100, 1'b0, 4'b0000, 4, "stall1");
    cyc(4'b0100, 1'b0, 4'b0000, 4, "stall2");
    cyc(4'b0100, 1'b1, 4'b0000, 3, "stall_pop");
    cyc(4'b0100, 1'b0, 4'b0100, 4, "resume");
    cyc(4'b0000, 1'b1, 4'b0000, 3, "dr3");
    cyc(4'b0000, 1'b1, 4'b0000, 2, "dr2");
    cyc(4'b0000, 1'b1, 4'b0000, 1, "dr1");
    cyc(4'b0000, 1'b1, 4'b0000, 0, "dr0");

`ifdef FIFO_ARB_BURST_LOCK_EN
    // Burst from requester 1 holds the grant against 0 and 2.
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset    = 1'b0;
    prev_gnt = '0;
    rl = 4'b0001;
    cyc(4'b0111, 1'b0, 4'b0001, 1, "lk_pre");
    cyc(4'b0111, 1'b1, 4'b0010, 1, "lk_b0");
    cyc(4'b0111, 1'b1, 4'b0010, 1, "lk_b1");
    rl = 4'b0011;
    cyc(4'b0111, 1'b1, 4'b0010, 1, "lk_b2");
    rl = 4'b0000;
    cyc(4'b0111, 1'b1, 4'b0100, 1, "lk_after");
    rl = 4'b1111;
    cyc(4'b0000, 1'b1, 4'b0000, 0, "lk_drain");
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
